// File: rtl/spike_time_encoder_if.sv
// spike_time_encoder_if
//   Input handshake bundle of the spike time encoder: one vector of per-synapse
//   spike times with a valid/ready pair.
//
//   Handshake: a vector moves from master to slave on a rising clock edge where
//   times_valid && times_ready are both high. The master may hold times_valid
//   high while times_ready is low; the vector then waits and is not consumed.
//   times_in only matters on the transfer edge.
//
//   Signals
//     times_in     master -> slave  [NUM_SPIKES][TBITS] spike time per input
//     times_valid  master -> slave  times_in holds a vector to transfer
//     times_ready  slave  -> master slave can take a vector on this edge
interface spike_time_encoder_if #(
    parameter int NUM_SPIKES = 8,
    parameter int TBITS      = 4
);
    logic [NUM_SPIKES-1:0][TBITS-1:0] times_in;
    logic                             times_valid;
    logic                             times_ready;

    modport master (
        output times_in,
        output times_valid,
        input  times_ready
    );

    modport slave (
        input  times_in,
        input  times_valid,
        output times_ready
    );
endinterface

// File: rtl/spike_time_encoder.sv
// spike_time_encoder
//   Upstream stage of the neuron. Accepts one vector of spike times (one per
//   synapse) and replays it as a temporal spike train over one gamma cycle of
//   GAMMA_LEN steps, followed by GAP_LEN rest cycles that clear the neuron.
//   A one-entry pending buffer lets the next vector load without a bubble.
//
//   Parameters
//     NUM_SPIKES  number of synaptic inputs
//     TBITS       width of one spike time (default: wmax = 7 -> 4 bits)
//     GAMMA_LEN   steps per gamma, 1 .. 2**TBITS-1
//     GAP_LEN     rest cycles after each gamma, 0 = no rest
//     STICKY      0: one-cycle spike pulse, 1: hold from spike time to gamma end
//
//   Ports
//     clk          clock, all state on the rising edge
//     rst          asynchronous active-high reset
//     times_bus    slave side of the spike time handshake
//     spikes_out   [NUM_SPIKES] spike train, feeds the neuron spikes_in
//     step         time step within the gamma, 0 outside RUN
//     gamma_start  high during step 0 of each gamma
//     gamma_done   high during step GAMMA_LEN-1 of each gamma
//     gamma_rst    high during every rest cycle
//     busy         FSM is not IDLE
//     fsm_state    FSM state for observation (0 IDLE, 1 RUN, 2 REST)
module spike_time_encoder #(
    parameter int NUM_SPIKES = 8,
    parameter int TBITS      = 4,
    parameter int GAMMA_LEN  = 8,
    parameter int GAP_LEN    = 1,
    parameter int STICKY     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    spike_time_encoder_if.slave   times_bus,
    output logic [NUM_SPIKES-1:0] spikes_out,
    output logic [TBITS-1:0]      step,
    output logic                  gamma_start,
    output logic                  gamma_done,
    output logic                  gamma_rst,
    output logic                  busy,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        REST = 2'd2
    } state_t;

    // The gap counter only ever counts up to GAP_LEN-1, so it never wraps.
    localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic [TBITS-1:0] STEP_LAST = TBITS'(GAMMA_LEN - 1);
    localparam logic [TBITS-1:0] GAMMA_END = TBITS'(GAMMA_LEN);

    state_t                           state;
    logic [TBITS-1:0]                 step_q;
    logic [GAP_W-1:0]                 gap_cnt;
    logic [NUM_SPIKES-1:0][TBITS-1:0] active;
    logic [NUM_SPIKES-1:0][TBITS-1:0] pending;
    logic                             pending_valid;
    logic                             accept;
    logic                             load;

    assign times_bus.times_ready = !pending_valid;
    assign accept = times_bus.times_valid && !pending_valid;

    // load: pending moves into active and a new gamma starts at step 0.
    always_comb begin
        load = 1'b0;
        case (state)
            IDLE:    load = pending_valid;
            RUN:     load = (GAP_LEN == 0) && (step_q == STEP_LAST) && pending_valid;
            REST:    load = (gap_cnt == GAP_LAST) && pending_valid;
            default: load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            step_q        <= '0;
            gap_cnt       <= '0;
            active        <= '1;
            pending       <= '1;
            pending_valid <= 1'b0;
        end else begin
            // accept and load are mutually exclusive (accept needs an empty
            // buffer, load a full one); the ordering keeps a full buffer full
            // should both ever coincide.
            if (accept) begin
                pending       <= times_bus.times_in;
                pending_valid <= 1'b1;
            end else if (load) begin
                pending_valid <= 1'b0;
            end

            if (load) begin
                active <= pending;
                state  <= RUN;
                step_q <= '0;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    RUN: begin
                        if (step_q == STEP_LAST) begin
                            step_q  <= '0;
                            gap_cnt <= '0;
                            state   <= (GAP_LEN > 0) ? REST : IDLE;
                        end else begin
                            step_q <= step_q + 1'b1;
                        end
                    end
                    REST: begin
                        if (gap_cnt == GAP_LAST) begin
                            state <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Spike decode from registered state only; times beyond the gamma never
    // match because step stops at GAMMA_LEN-1.
    always_comb begin
        spikes_out = '0;
        if (state == RUN) begin
            for (int i = 0; i < NUM_SPIKES; i++) begin
                if (STICKY != 0) begin
                    spikes_out[i] = (active[i] <= step_q) && (active[i] < GAMMA_END);
                end else begin
                    spikes_out[i] = (active[i] == step_q);
                end
            end
        end
    end

    assign step        = (state == RUN) ? step_q : '0;
    assign gamma_start = (state == RUN) && (step_q == '0);
    assign gamma_done  = (state == RUN) && (step_q == STEP_LAST);
    assign gamma_rst   = (state == REST);
    assign busy        = (state != IDLE);
    assign fsm_state   = state;

endmodule
